// File: rtl/psum_acc_ctrl.sv
// psum_acc_ctrl: sequences K read-modify-write passes of psum beats over N BRAM rows, then drains the rows.
// Overwrite on pass 0, accumulate afterwards; the N=1 back-to-back hazard is covered by a one-beat forward path.
module psum_acc_ctrl #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int PASS_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic [ADDR_WIDTH:0]            cfg_num_rows,
    input  logic [PASS_WIDTH-1:0]          cfg_num_passes,
    output logic                           busy,
    output logic                           done,
    input  logic                           psum_valid,
    output logic                           psum_ready,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] psum_in,
    output logic                           acc_clear,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0] acc_psum,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0] acc_rdata,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] acc_wdata,
    output logic                           bram_ren,
    output logic [ADDR_WIDTH-1:0]          bram_raddr,
    input  logic [ARRAY_DIM*ACC_WIDTH-1:0] bram_rdata,
    output logic                           bram_wen,
    output logic [ADDR_WIDTH-1:0]          bram_waddr,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0] bram_wdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0] out_data,
    output logic                           out_last
);
    localparam int VW = ARRAY_DIM * ACC_WIDTH;
    localparam logic [ADDR_WIDTH:0]   ONE_R = 1;
    localparam logic [PASS_WIDTH-1:0] ONE_P = 1;
    typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH:0] n_q, n_d, row_q, row_d;
    logic [PASS_WIDTH-1:0] k_q, k_d, pass_q, pass_d;
    logic [VW-1:0] psum_q, psum_d, fwd_data_q, fwd_data_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic s1_valid_q, s1_valid_d, s1_clear_q, s1_clear_d, fwd_q, fwd_d;
    logic out_valid_q, out_valid_d, last_q, last_d;
    logic accept, issue, row_end;

    assign accept  = state_q == ACCUM && psum_valid;
    assign issue   = state_q == DRAIN && row_q < n_q && (!out_valid_q || out_ready);
    assign row_end = row_q == n_q - ONE_R;

    assign busy       = state_q == ACCUM || state_q == FLUSH || state_q == DRAIN;
    assign done       = state_q == DONE;
    assign psum_ready = state_q == ACCUM;
    assign acc_clear  = s1_valid_q && s1_clear_q;
    assign acc_psum   = psum_q;
    assign acc_rdata  = fwd_q ? fwd_data_q : bram_rdata;
    assign bram_ren   = accept || issue;
    assign bram_raddr = row_q[ADDR_WIDTH-1:0];
    assign bram_wen   = s1_valid_q;
    assign bram_waddr = s1_addr_q;
    assign bram_wdata = acc_wdata;
    assign out_valid  = out_valid_q;
    assign out_data   = bram_rdata;
    assign out_last   = out_valid_q && last_q;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        row_d       = row_q;
        pass_d      = pass_q;
        psum_d      = psum_q;
        s1_valid_d  = accept;
        s1_addr_d   = s1_addr_q;
        s1_clear_d  = s1_clear_q;
        fwd_d       = 1'b0;
        fwd_data_d  = fwd_data_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (accept) begin
            psum_d     = psum_in;
            s1_addr_d  = row_q[ADDR_WIDTH-1:0];
            s1_clear_d = pass_q == '0;
            // Row still being written this cycle: the BRAM would return stale data next cycle.
            fwd_d      = s1_valid_q && s1_addr_q == row_q[ADDR_WIDTH-1:0];
            fwd_data_d = acc_wdata;
            row_d      = row_end ? '0 : row_q + ONE_R;
            pass_d     = row_end ? pass_q + ONE_P : pass_q;
        end
        if (issue) begin
            row_d       = row_q + ONE_R;
            out_valid_d = 1'b1;
            last_d      = row_end;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: if (cfg_start) begin
                if (cfg_num_rows == '0 || cfg_num_passes == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = ACCUM;
                    n_d     = cfg_num_rows;
                    k_d     = cfg_num_passes;
                    row_d   = '0;
                    pass_d  = '0;
                end
            end
            ACCUM: state_d = (accept && row_end && pass_q == k_q - ONE_P) ? FLUSH : ACCUM;
            FLUSH: begin
                state_d = DRAIN;
                row_d   = '0;
            end
            DRAIN: state_d = (out_valid_q && out_ready && last_q) ? DONE : DRAIN;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            k_q         <= '0;
            row_q       <= '0;
            pass_q      <= '0;
            psum_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_clear_q  <= 1'b0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            row_q       <= row_d;
            pass_q      <= pass_d;
            psum_q      <= psum_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_clear_q  <= s1_clear_d;
            fwd_q       <= fwd_d;
            fwd_data_q  <= fwd_data_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end
endmodule

// File: tb/tb_psum_acc_ctrl.sv
// tb_psum_acc_ctrl: random psum/drain traffic against a BRAM + accumulator environment,
// checking drained rows against per-row sums computed directly from the accepted beats.
module tb_psum_acc_ctrl;
    localparam int AD = 16, AW = 32, ADW = 8, PW = 16, VW = AD * AW;

    logic clk = 1'b0, rst = 1'b1;
    logic cfg_start = 1'b0;
    logic [ADW:0] cfg_num_rows = '0;
    logic [PW-1:0] cfg_num_passes = '0;
    logic busy, done, psum_valid = 1'b0, psum_ready, acc_clear;
    logic [VW-1:0] psum_in = '0, acc_psum, acc_rdata, acc_wdata, bram_rdata = '0, bram_wdata, out_data;
    logic bram_ren, bram_wen, out_valid, out_ready = 1'b0, out_last;
    logic [ADW-1:0] bram_raddr, bram_waddr;

    always #5 clk = ~clk;

    psum_acc_ctrl #(.ARRAY_DIM(AD), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .PASS_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_rows(cfg_num_rows),
        .cfg_num_passes(cfg_num_passes), .busy(busy), .done(done), .psum_valid(psum_valid),
        .psum_ready(psum_ready), .psum_in(psum_in), .acc_clear(acc_clear), .acc_psum(acc_psum),
        .acc_rdata(acc_rdata), .acc_wdata(acc_wdata), .bram_ren(bram_ren), .bram_raddr(bram_raddr),
        .bram_rdata(bram_rdata), .bram_wen(bram_wen), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    // Environment: read-before-write BRAM with 1-cycle latency, and a lane-wise accumulator.
    logic [VW-1:0] mem [0:255];
    logic scramble = 1'b0;
    logic [AW-1:0] scr_val = '0;
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 256; i++) mem[i] <= {AD{scr_val}};
        end else begin
            if (bram_wen) mem[bram_waddr] <= bram_wdata;
            if (bram_ren) bram_rdata <= mem[bram_raddr];
        end
    end
    always_comb begin
        acc_wdata = '0;
        for (int l = 0; l < AD; l++)
            acc_wdata[l*AW+:AW] = acc_clear ? acc_psum[l*AW+:AW] : acc_psum[l*AW+:AW] + acc_rdata[l*AW+:AW];
    end

    int checks = 0, failures = 0;
    logic [AW-1:0] exp_mem [0:255][0:AD-1];

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ready"}, psum_ready, 1'b0);
        check({tag, "_ren"}, bram_ren, 1'b0);
        check({tag, "_wen"}, bram_wen, 1'b0);
        check({tag, "_ovalid"}, out_valid, 1'b0);
        check({tag, "_olast"}, out_last, 1'b0);
        check({tag, "_clear"}, acc_clear, 1'b0);
        check({tag, "_psum"}, acc_psum, '0);
    endtask

    // pat: 0 random lanes, 1 lane l = beat+1+l, 2 constant 5. abort_after<0 runs to completion.
    task automatic run(input int n, input int k, input int vp, input int rp, input int pat, input int abort_after);
        int acc = 0, got_rows = 0, cyc = 0, row, budget;
        logic stall = 1'b0;
        logic [VW-1:0] held = '0, v, e;
        budget = 30 * n * k + 30 * n + 100;
        @(negedge clk);
        cfg_num_rows = n[ADW:0];
        cfg_num_passes = k[PW-1:0];
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        if (n == 0 || k == 0) begin
            check("zero_done", done, 1'b1);
            check("zero_busy", busy, 1'b0);
            check("zero_ren", bram_ren, 1'b0);
            check("zero_wen", bram_wen, 1'b0);
            @(negedge clk);
            #1;
            check("zero_done_once", done, 1'b0);
            check("zero_ren2", bram_ren, 1'b0);
            return;
        end
        check("start_busy", busy, 1'b1);
        check("start_ready", psum_ready, 1'b1);
        forever begin
            if (acc == abort_after) begin
                psum_valid = 1'b0;
                out_ready = 1'b0;
                rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            for (int l = 0; l < AD; l++)
                v[l*AW+:AW] = pat == 0 ? AW'($urandom) : pat == 1 ? AW'(acc + 1 + l) : AW'(5);
            psum_in = v;
            psum_valid = acc < n * k && $urandom_range(99) < vp;
            out_ready = $urandom_range(99) < rp;
            cfg_start = $urandom_range(7) == 0;
            cfg_num_rows = ADW'($urandom_range(3)) + 1'b1;
            #1;
            if (stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, held);
            end
            stall = out_valid && !out_ready;
            held = out_data;
            if (psum_valid && psum_ready) begin
                row = acc % n;
                for (int l = 0; l < AD; l++)
                    exp_mem[row][l] = (acc < n ? AW'(0) : exp_mem[row][l]) + v[l*AW+:AW];
                acc++;
            end
            if (out_valid && out_ready) begin
                for (int l = 0; l < AD; l++) e[l*AW+:AW] = exp_mem[got_rows % 256][l];
                check($sformatf("row%0d_n%0d_k%0d", got_rows, n, k), out_data, e);
                check("out_last", out_last, got_rows == n - 1);
                got_rows++;
            end
            if (done) begin
                check("done_busy", busy, 1'b0);
                check("rows_drained", got_rows, n);
                check("beats_taken", acc, n * k);
                break;
            end
            if (++cyc > budget) begin
                check("timeout_done", done, 1'b1);
                break;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        cfg_start = 1'b0;
        psum_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("done_pulse_once", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run(4, 1, 100, 100, 1, -1);
        @(negedge clk);
        scramble = 1'b1;
        scr_val = 32'hDEAD;
        @(negedge clk);
        scramble = 1'b0;
        run(4, 3, 100, 100, 2, -1);
        run(1, 4, 100, 100, 1, -1);
        run(3, 2, 50, 50, 0, -1);
        run(1, 5, 70, 60, 0, -1);
        run(3, 3, 100, 100, 0, 6);
        run(2, 1, 100, 100, 1, -1);
        run(4, 0, 100, 100, 0, -1);
        run(0, 3, 100, 100, 0, -1);
        repeat (6) run($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(30, 100), $urandom_range(30, 100), 0, -1);
        run(256, 2, 90, 90, 0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_acc_ctrl.md
# psum_acc_ctrl

Sequencer for the partial-sum accumulation datapath. It accepts one PE-array psum vector per beat and drives the psum BRAM read/write ports and the combinational accumulator (`acc_clear`, `acc_psum`, `acc_rdata`), taking back the accumulator result (`acc_wdata`). It runs K kernel passes over N output rows: the first pass overwrites, later passes accumulate. It then drains the N accumulated rows through a valid/ready output stream.

## Interface
- ARRAY_DIM, 16, lanes per psum vector
- ACC_WIDTH, 32, bits per lane
- ADDR_WIDTH, 8, BRAM row address width
- PASS_WIDTH, 16, pass counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  start pulse, sampled only in IDLE
- cfg_num_rows  in  ADDR_WIDTH+1  N, rows per pass (1..2^ADDR_WIDTH), latched at start
- cfg_num_passes  in  PASS_WIDTH  K, passes, latched at start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- psum_valid  in  1  psum beat offered
- psum_ready  out  1  beat accepted when valid&&ready
- psum_in  in  ARRAY_DIM*ACC_WIDTH  psum vector
- acc_clear  out  1  to accumulator: overwrite
- acc_psum  out  ARRAY_DIM*ACC_WIDTH  to accumulator: registered psum
- acc_rdata  out  ARRAY_DIM*ACC_WIDTH  to accumulator: BRAM data or forwarded data
- acc_wdata  in  ARRAY_DIM*ACC_WIDTH  accumulator result
- bram_ren  out  1  read enable; BRAM read latency is 1, and output holds while ren=0
- bram_raddr  out  ADDR_WIDTH  read address
- bram_rdata  in  ARRAY_DIM*ACC_WIDTH  read data
- bram_wen  out  1  write enable
- bram_waddr  out  ADDR_WIDTH  write address
- bram_wdata  out  ARRAY_DIM*ACC_WIDTH  equals acc_wdata
- out_valid  out  1  drain beat valid
- out_ready  in  1  drain consumer ready
- out_data  out  ARRAY_DIM*ACC_WIDTH  equals bram_rdata
- out_last  out  1  marks row N-1 of the drain

## Operation
- States: IDLE, ACCUM, FLUSH, DRAIN, DONE.
- IDLE:
  - cfg_start with N≥1 and K≥1: latch N and K, clear row_cnt and pass_cnt, go to ACCUM.
  - cfg_start with N=0 or K=0: go to DONE with no BRAM access.
- ACCUM:
  - psum_ready=1.
  - Accepted beat at cycle t:
    - bram_ren=1 and bram_raddr=row_cnt.
    - Register psum_q←psum_in, s1_valid←1, s1_addr←row_cnt, s1_clear←(pass_cnt==0).
    - row_cnt wraps N-1→0 and increments pass_cnt.
  - Cycle t+1:
    - acc_psum=psum_q and acc_clear=s1_clear.
    - bram_wen=s1_valid, bram_waddr=s1_addr, bram_wdata=acc_wdata.
  - When no beat was accepted at t, s1_valid=0 at t+1.
  - Accepting row N-1 of pass K-1 moves the block to FLUSH.
- Forwarding:
  - If a beat is accepted at t while s1_valid && s1_addr==row_cnt (only possible when N=1), set fwd←1 and fwd_data←acc_wdata at t.
  - At t+1, acc_rdata=fwd_data; otherwise acc_rdata=bram_rdata.
- FLUSH: exactly one cycle, during which the final write completes. psum_ready=0. Next state is DRAIN with row_cnt=0.
- DRAIN:
  - Issue a read (bram_ren=1, raddr=row_cnt, row_cnt++) when rows remain and (!out_valid || out_ready).
  - out_valid←1 on issue; out_valid←0 on handshake with no new issue.
  - out_last is high while the presented row is N-1.
  - After the handshake of row N-1, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- No arithmetic is performed here; all sums come from the accumulator (modulo 2^ACC_WIDTH per lane).
- Starts arriving outside IDLE are ignored.

## Timing
- Reset values: all outputs 0, state IDLE, all counters and registers 0.
- Asynchronous reset mid-operation:
  - Aborts immediately; any in-flight write is dropped (bram_wen=0).
  - BRAM contents are undefined for the next run, which the next run's first pass overwrites.
- Start at cycle t → busy=1 and psum_ready=1 at t+1.
- Psum throughput is 1 beat/cycle. Write occurs exactly 1 cycle after acceptance.
- Read-after-write distance ≥2 cycles needs no forwarding; distance 1 (N=1, back-to-back beats) uses the forward path.
- Drain:
  - Throughput is 1 row/cycle while out_ready=1.
  - While out_ready=0, out_data holds stable because bram_ren=0.
- Done pulses in the cycle after the last drain handshake. busy falls in that same cycle.

## Test plan
- N=4, K=1, psum lane0 = 1,2,3,4 → writes to addr 0..3 with acc_clear=1. Drain lane0 gives 1,2,3,4 and out_last on the 4th beat. done pulses once.
- N=4, K=3, every beat lane0=5, BRAM preloaded with 0xDEAD → drain gives 15 on all rows (pass 0 overwrites the preload).
- N=1, K=4, back-to-back beats 1,2,3,4 → fwd is used on beats 2–4. Drain gives 10.
- N=3, K=2, psum_valid toggling 1/0 and out_ready pattern 1,0,0,1 → sums are still correct, with no dropped or duplicated rows. out_data stays stable while stalled.
- Reset asserted mid-ACCUM (pass 1, row 2) → all outputs are 0 asynchronously. A following N=2, K=1 run completes correctly.
- cfg_num_passes=0 → done pulses 1 cycle after start, with bram_ren=0 and bram_wen=0 throughout. cfg_start while busy is ignored.
